// File: rtl/rv32_pkg.sv
// -----------------------------------------------------------------------------
// rv32_pkg -- shared constants and types for the instruction fetch path.
//
// Contents:
//   XLEN_DEFAULT  default PC/address width
//   INSTR_W       instruction word width
//   PC_INC        fetch address step between sequential instructions
//   fetch_entry_t one fetch-queue entry {pc, instr} at the default width
// -----------------------------------------------------------------------------
package rv32_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;
    localparam int PC_INC       = 4;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0] pc;
        logic [INSTR_W-1:0]      instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo -- fetch queue between instruction memory and decode.
//
// Synchronous FIFO with flush. Pointers are $clog2(DEPTH) bits wide, so with a
// power-of-two DEPTH they wrap modulo DEPTH on their own.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (empties the queue)
//   i_flush      empty the queue on the next edge; wins over push/pop
//   i_push       write i_push_data at the tail
//   i_push_data  entry to write
//   i_pop        drop the head entry (ignored when empty)
//   o_head       current head entry (undefined content when o_count == 0)
//   o_count      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_fifo
    import rv32_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  entry_t                 i_push_data,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    entry_t        r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != FULL) || w_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: ;
            endcase
        end
    end

    // NOTE: storage has no reset; an entry is only observed after it has been
    // written, and the parent masks the head while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- sequential instruction fetch with redirect support.
//
// Issues in-order requests to instruction memory, queues the returned words
// with their PCs and presents the queue head to decode. Requests are only
// issued while queued + in-flight entries leave room, so a response always
// has a free slot. A redirect flushes the queue, restarts fetch at the
// word-aligned target and arms a drop counter that swallows every response
// still in flight from before the redirect.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   redirect_valid/_pc       branch/jump redirect strobe and target
//   imem_req_valid/_addr     fetch request to memory
//   imem_req_ready           memory accepts the request
//   imem_rsp_valid/_data     in-order instruction return
//   out_valid/_pc/_pc_4/_instr  queue head to decode (zero when empty)
//   out_ready                decode consumes the head
//   count                    queue occupancy
// -----------------------------------------------------------------------------
module fetch_unit
    import rv32_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect_valid,
    input  logic [XLEN-1:0]        redirect_pc,
    output logic                   imem_req_valid,
    output logic [XLEN-1:0]        imem_req_addr,
    input  logic                   imem_req_ready,
    input  logic                   imem_rsp_valid,
    input  logic [INSTR_W-1:0]     imem_rsp_data,
    output logic                   out_valid,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_pc_4,
    output logic [INSTR_W-1:0]     out_instr,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [XLEN-1:0] INC     = XLEN'(PC_INC);

    // Same layout as fetch_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [XLEN-1:0] r_pc;           // next fetch address
    logic [XLEN-1:0] r_rsp_pc;       // PC of the next non-stale response
    logic [CW-1:0]   r_outstanding;  // requests accepted, not yet answered
    logic [CW-1:0]   r_drop;         // stale responses still to discard

    logic [CW-1:0]   w_outstanding_nxt;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    entry_t          w_head;
    entry_t          w_push_data;

    assign w_redirect_pc  = {redirect_pc[XLEN-1:2], 2'b00};

    // Reset gates the request so it stays low while rst is asserted and rises
    // as soon as it is released.
    assign imem_req_valid = rst && (({1'b0, w_count} + {1'b0, r_outstanding}) < CREDITS);
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response in the redirect cycle is always stale; otherwise the drop
    // counter decides whether it belongs to the pre-redirect stream.
    assign w_rsp_keep = imem_rsp_valid && !redirect_valid && (r_drop == '0);
    assign w_rsp_drop = imem_rsp_valid && !redirect_valid && (r_drop != '0);
    assign w_pop      = out_ready && !redirect_valid;

    // NOTE: the default assignment first keeps this purely combinational;
    // a path that left w_outstanding_nxt unassigned would infer a latch.
    always_comb begin
        w_outstanding_nxt = r_outstanding;
        case ({w_req_fire, imem_rsp_valid})
            2'b10:   w_outstanding_nxt = r_outstanding + ONE;
            2'b01:   w_outstanding_nxt = r_outstanding - ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_nxt;
            if (redirect_valid) begin
                // Everything still in flight after this edge, including a
                // request accepted this cycle, belongs to the old stream.
                r_pc     <= w_redirect_pc;
                r_rsp_pc <= w_redirect_pc;
                r_drop   <= w_outstanding_nxt;
            end else begin
                if (w_req_fire) r_pc     <= r_pc + INC;
                if (w_rsp_keep) r_rsp_pc <= r_rsp_pc + INC;
                if (w_rsp_drop) r_drop   <= r_drop - ONE;
            end
        end
    end

    assign w_push_data = '{pc: r_rsp_pc, instr: imem_rsp_data};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_flush     (redirect_valid),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign count     = w_count;
    assign out_valid = (w_count != '0);
    assign out_pc    = out_valid ? w_head.pc       : '0;
    assign out_pc_4  = out_valid ? w_head.pc + INC : '0;
    assign out_instr = out_valid ? w_head.instr    : '0;

endmodule
